// File: rtl/gb_pkg.sv
// Shared encodings for the CPU register control bus: register addresses,
// write-source selects, pair selects and DMG post-boot register values.
`timescale 1ns/1ps
package gb_pkg;

  typedef enum logic [2:0] {
    REG_B  = 3'b000,
    REG_C  = 3'b001,
    REG_D  = 3'b010,
    REG_E  = 3'b011,
    REG_H  = 3'b100,
    REG_L  = 3'b101,
    MEM_HL = 3'b110,
    REG_A  = 3'b111
  } reg_addr_t;

  typedef enum logic [1:0] {
    SBUS  = 2'b00,
    ALU   = 2'b01,
    MEM   = 2'b10,
    DEBUG = 2'b11
  } src_sel_t;

  typedef enum logic [1:0] {
    PAIR_BC = 2'b00,
    PAIR_DE = 2'b01,
    PAIR_HL = 2'b10,
    PAIR_AF = 2'b11
  } pair_sel_t;

  // Register contents after the DMG boot ROM hands over
  localparam logic [7:0] BOOT_A = 8'h01;
  localparam logic [7:0] BOOT_F = 8'hB0;
  localparam logic [7:0] BOOT_B = 8'h00;
  localparam logic [7:0] BOOT_C = 8'h13;
  localparam logic [7:0] BOOT_D = 8'h00;
  localparam logic [7:0] BOOT_E = 8'hD8;
  localparam logic [7:0] BOOT_H = 8'h01;
  localparam logic [7:0] BOOT_L = 8'h4D;

  // Reset value of one register: boot value, or zero for a cold start
  function automatic logic [7:0] rst_val(input bit post_boot, input logic [7:0] boot);
    return post_boot ? boot : 8'h00;
  endfunction

endpackage

// File: rtl/reg_src_mux.sv
// 4:1 selector for the 8-bit register write data.
`timescale 1ns/1ps
module reg_src_mux
  import gb_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [7:0] sbus_data,
  input  logic [7:0] alu_data,
  input  logic [7:0] mem_data,
  input  logic [7:0] debug_data,
  output logic [7:0] wr_data
);

  // Pick the write source named by sel
  always_comb begin
    wr_data = 8'h00;
    case (sel)
      SBUS:    wr_data = sbus_data;
      ALU:     wr_data = alu_data;
      MEM:     wr_data = mem_data;
      DEBUG:   wr_data = debug_data;
      default: wr_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// General-purpose register file: B C D E H L A plus flags, one read and
// one 8-bit write per cycle, pair writes, flag updates and HL stepping.
// Next-state values are built with the collision priority folded in, so
// the read path can forward them (write-first) without extra logic.
`timescale 1ns/1ps
module reg_file
  import gb_pkg::*;
#(
  parameter bit POST_BOOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_rd_en,
  input  logic [2:0]  reg_rd_addr,
  input  logic        reg_wr_en,
  input  logic [2:0]  reg_wr_addr,
  input  logic [1:0]  reg_src_sel,
  input  logic [7:0]  sbus_data,
  input  logic [7:0]  alu_data,
  input  logic [7:0]  mem_data,
  input  logic [7:0]  debug_data,
  input  logic        pair_wr_en,
  input  logic [1:0]  pair_sel,
  input  logic [15:0] pair_data,
  input  logic        flag_wr_en,
  input  logic [3:0]  flag_in,
  input  logic        hl_inc,
  input  logic        hl_dec,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [7:0]  a_out,
  output logic [7:0]  f_out,
  output logic [15:0] hl_out
);

  localparam logic [7:0] RST_A = rst_val(POST_BOOT, BOOT_A);
  localparam logic [7:0] RST_F = rst_val(POST_BOOT, BOOT_F);
  localparam logic [7:0] RST_B = rst_val(POST_BOOT, BOOT_B);
  localparam logic [7:0] RST_C = rst_val(POST_BOOT, BOOT_C);
  localparam logic [7:0] RST_D = rst_val(POST_BOOT, BOOT_D);
  localparam logic [7:0] RST_E = rst_val(POST_BOOT, BOOT_E);
  localparam logic [7:0] RST_H = rst_val(POST_BOOT, BOOT_H);
  localparam logic [7:0] RST_L = rst_val(POST_BOOT, BOOT_L);

  // Storage; only the upper flag nibble exists, the low nibble reads as 0
  logic [7:0]  b_r, c_r, d_r, e_r, h_r, l_r, a_r;
  logic [3:0]  f_r;

  logic [7:0]  wr_data_s;
  logic        wr_ok_s;
  logic        wr_b_s, wr_c_s, wr_d_s, wr_e_s, wr_h_s, wr_l_s, wr_a_s;
  logic        pair_bc_s, pair_de_s, pair_hl_s, pair_af_s;
  logic        hl_wr_s;
  logic [15:0] hl_cur_s, hl_step_s, hl_base_s;
  logic [7:0]  b_nx_s, c_nx_s, d_nx_s, e_nx_s, h_nx_s, l_nx_s, a_nx_s;
  logic [3:0]  f_nx_s;
  logic [7:0]  rd_nx_s;
  logic        unused_pair_lo_s;

  reg_src_mux u_src_mux (
    .sel        (reg_src_sel),
    .sbus_data  (sbus_data),
    .alu_data   (alu_data),
    .mem_data   (mem_data),
    .debug_data (debug_data),
    .wr_data    (wr_data_s)
  );

  // The (HL) slot is memory, not a register: such writes touch nothing here
  assign wr_ok_s = reg_wr_en && (reg_wr_addr != MEM_HL);
  assign wr_b_s  = wr_ok_s && (reg_wr_addr == REG_B);
  assign wr_c_s  = wr_ok_s && (reg_wr_addr == REG_C);
  assign wr_d_s  = wr_ok_s && (reg_wr_addr == REG_D);
  assign wr_e_s  = wr_ok_s && (reg_wr_addr == REG_E);
  assign wr_h_s  = wr_ok_s && (reg_wr_addr == REG_H);
  assign wr_l_s  = wr_ok_s && (reg_wr_addr == REG_L);
  assign wr_a_s  = wr_ok_s && (reg_wr_addr == REG_A);

  assign pair_bc_s = pair_wr_en && (pair_sel == PAIR_BC);
  assign pair_de_s = pair_wr_en && (pair_sel == PAIR_DE);
  assign pair_hl_s = pair_wr_en && (pair_sel == PAIR_HL);
  assign pair_af_s = pair_wr_en && (pair_sel == PAIR_AF);

  // Flag low nibble is hard-wired to zero, so these pair bits are dropped
  assign unused_pair_lo_s = ^pair_data[3:0];

  // Any explicit write into H or L takes HL away from the inc/dec logic
  assign hl_wr_s  = wr_h_s || wr_l_s || pair_hl_s;
  assign hl_cur_s = {h_r, l_r};

  // 16-bit modulo step of HL; inc and dec together cancel out
  always_comb begin
    hl_step_s = hl_cur_s;
    case ({hl_inc, hl_dec})
      2'b10:   hl_step_s = hl_cur_s + 16'd1;
      2'b01:   hl_step_s = hl_cur_s - 16'd1;
      default: hl_step_s = hl_cur_s;
    endcase
  end

  assign hl_base_s = hl_wr_s ? hl_cur_s : hl_step_s;

  // Next values, highest priority source outermost: pair > 8-bit > flag/HL step
  assign b_nx_s = pair_bc_s ? pair_data[15:8] : (wr_b_s ? wr_data_s : b_r);
  assign c_nx_s = pair_bc_s ? pair_data[7:0]  : (wr_c_s ? wr_data_s : c_r);
  assign d_nx_s = pair_de_s ? pair_data[15:8] : (wr_d_s ? wr_data_s : d_r);
  assign e_nx_s = pair_de_s ? pair_data[7:0]  : (wr_e_s ? wr_data_s : e_r);
  assign h_nx_s = pair_hl_s ? pair_data[15:8] : (wr_h_s ? wr_data_s : hl_base_s[15:8]);
  assign l_nx_s = pair_hl_s ? pair_data[7:0]  : (wr_l_s ? wr_data_s : hl_base_s[7:0]);
  assign a_nx_s = pair_af_s ? pair_data[15:8] : (wr_a_s ? wr_data_s : a_r);
  assign f_nx_s = pair_af_s ? pair_data[7:4]  : (flag_wr_en ? flag_in : f_r);

  // Read mux over next-state values gives write-first forwarding
  always_comb begin
    rd_nx_s = 8'h00;
    case (reg_rd_addr)
      REG_B:   rd_nx_s = b_nx_s;
      REG_C:   rd_nx_s = c_nx_s;
      REG_D:   rd_nx_s = d_nx_s;
      REG_E:   rd_nx_s = e_nx_s;
      REG_H:   rd_nx_s = h_nx_s;
      REG_L:   rd_nx_s = l_nx_s;
      REG_A:   rd_nx_s = a_nx_s;
      MEM_HL:  rd_nx_s = 8'h00;
      default: rd_nx_s = 8'h00;
    endcase
  end

  // Register storage update
  always_ff @(posedge clk) begin
    if (rst) begin
      b_r <= RST_B;
      c_r <= RST_C;
      d_r <= RST_D;
      e_r <= RST_E;
      h_r <= RST_H;
      l_r <= RST_L;
      a_r <= RST_A;
      f_r <= RST_F[7:4];
    end else begin
      b_r <= b_nx_s;
      c_r <= c_nx_s;
      d_r <= d_nx_s;
      e_r <= e_nx_s;
      h_r <= h_nx_s;
      l_r <= l_nx_s;
      a_r <= a_nx_s;
      f_r <= f_nx_s;
    end
  end

  // Registered read port; data holds while no read is requested
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= reg_rd_en;
      if (reg_rd_en) begin
        rd_data <= rd_nx_s;
      end else begin
        rd_data <= rd_data;
      end
    end
  end

  assign a_out  = a_r;
  assign f_out  = {f_r, 4'h0};
  assign hl_out = {h_r, l_r};

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios with literal
// expectations plus a randomized run against an array-based register model.
`timescale 1ns/1ps
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_rd_en;
  logic [2:0]  reg_rd_addr;
  logic        reg_wr_en;
  logic [2:0]  reg_wr_addr;
  logic [1:0]  reg_src_sel;
  logic [7:0]  sbus_data, alu_data, mem_data, debug_data;
  logic        pair_wr_en;
  logic [1:0]  pair_sel;
  logic [15:0] pair_data;
  logic        flag_wr_en;
  logic [3:0]  flag_in;
  logic        hl_inc, hl_dec;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  a_out, f_out;
  logic [15:0] hl_out;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: registers indexed by their 3-bit address (slot 6 unused)
  logic [7:0] m_reg [8];
  logic [7:0] m_f;
  logic [7:0] m_rd;
  logic       m_valid;

  reg_file #(.POST_BOOT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_src_sel(reg_src_sel),
    .sbus_data(sbus_data), .alu_data(alu_data), .mem_data(mem_data), .debug_data(debug_data),
    .pair_wr_en(pair_wr_en), .pair_sel(pair_sel), .pair_data(pair_data),
    .flag_wr_en(flag_wr_en), .flag_in(flag_in),
    .hl_inc(hl_inc), .hl_dec(hl_dec),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .a_out(a_out), .f_out(f_out), .hl_out(hl_out)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; reg_rd_en = 1'b0; reg_rd_addr = 3'd0;
    reg_wr_en = 1'b0; reg_wr_addr = 3'd0; reg_src_sel = 2'd0;
    sbus_data = 8'h00; alu_data = 8'h00; mem_data = 8'h00; debug_data = 8'h00;
    pair_wr_en = 1'b0; pair_sel = 2'd0; pair_data = 16'h0000;
    flag_wr_en = 1'b0; flag_in = 4'h0; hl_inc = 1'b0; hl_dec = 1'b0;
  endtask

  // Apply the current inputs to the model using the architectural rules
  task automatic model_step();
    logic [7:0]  nr [8];
    logic [7:0]  nf;
    logic [7:0]  src;
    logic [15:0] hl;
    bit          hl_touched;
    if (rst) begin
      m_reg[0] = 8'h00; m_reg[1] = 8'h13; m_reg[2] = 8'h00; m_reg[3] = 8'hD8;
      m_reg[4] = 8'h01; m_reg[5] = 8'h4D; m_reg[6] = 8'h00; m_reg[7] = 8'h01;
      m_f = 8'hB0; m_rd = 8'h00; m_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 8; i++) nr[i] = m_reg[i];
    nf = m_f;
    case (reg_src_sel)
      2'd0: src = sbus_data;
      2'd1: src = alu_data;
      2'd2: src = mem_data;
      default: src = debug_data;
    endcase
    hl_touched = (reg_wr_en && (reg_wr_addr == 3'd4 || reg_wr_addr == 3'd5)) ||
                 (pair_wr_en && pair_sel == 2'd2);
    hl = {m_reg[4], m_reg[5]};
    if (!hl_touched && hl_inc && !hl_dec) hl = hl + 16'd1;
    if (!hl_touched && hl_dec && !hl_inc) hl = hl - 16'd1;
    nr[4] = hl[15:8]; nr[5] = hl[7:0];
    if (flag_wr_en) nf = {flag_in, 4'h0};
    if (reg_wr_en && reg_wr_addr != 3'd6) nr[reg_wr_addr] = src;
    if (pair_wr_en) begin
      case (pair_sel)
        2'd0: begin nr[0] = pair_data[15:8]; nr[1] = pair_data[7:0]; end
        2'd1: begin nr[2] = pair_data[15:8]; nr[3] = pair_data[7:0]; end
        2'd2: begin nr[4] = pair_data[15:8]; nr[5] = pair_data[7:0]; end
        default: begin nr[7] = pair_data[15:8]; nf = {pair_data[7:4], 4'h0}; end
      endcase
    end
    if (reg_rd_en) m_rd = (reg_rd_addr == 3'd6) ? 8'h00 : nr[reg_rd_addr];
    m_valid = reg_rd_en;
    for (int i = 0; i < 8; i++) m_reg[i] = nr[i];
    m_f = nf;
  endtask

  // One clock: update the model, then let outputs settle past the edge
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); idle();
    n_total++; if (a_out !== 8'h01) $display("FAIL reset_a: got %h want 01", a_out); else n_pass++;
    n_total++; if (f_out !== 8'hB0) $display("FAIL reset_f: got %h want b0", f_out); else n_pass++;
    n_total++; if (hl_out !== 16'h014D) $display("FAIL reset_hl: got %h want 014d", hl_out); else n_pass++;
    n_total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00)
      $display("FAIL reset_rd: got valid=%b data=%h want 0/00", rd_valid, rd_data); else n_pass++;
    reg_rd_en = 1'b1; reg_rd_addr = 3'd1; tick(); idle();
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 8'h13)
      $display("FAIL read_c: got valid=%b data=%h want 1/13", rd_valid, rd_data); else n_pass++;
    tick();
    n_total++; if (rd_valid !== 1'b0 || rd_data !== 8'h13)
      $display("FAIL read_hold: got valid=%b data=%h want 0/13", rd_valid, rd_data); else n_pass++;
  endtask

  task automatic test_write_forward();
    idle(); reg_wr_en = 1'b1; reg_wr_addr = 3'd0; reg_src_sel = 2'd1; alu_data = 8'h5A;
    sbus_data = 8'h11; mem_data = 8'h22; debug_data = 8'h33;
    reg_rd_en = 1'b1; reg_rd_addr = 3'd0; tick(); idle();
    n_total++; if (rd_data !== 8'h5A) $display("FAIL fwd_b: got %h want 5a", rd_data); else n_pass++;
    reg_rd_en = 1'b1; reg_rd_addr = 3'd0; tick(); idle();
    n_total++; if (rd_data !== 8'h5A) $display("FAIL reread_b: got %h want 5a", rd_data); else n_pass++;
  endtask

  task automatic test_hl_wrap();
    idle(); pair_wr_en = 1'b1; pair_sel = 2'd2; pair_data = 16'hFFFF; tick(); idle();
    n_total++; if (hl_out !== 16'hFFFF) $display("FAIL hl_pair: got %h want ffff", hl_out); else n_pass++;
    hl_inc = 1'b1; reg_rd_en = 1'b1; reg_rd_addr = 3'd4; tick(); idle();
    n_total++; if (hl_out !== 16'h0000) $display("FAIL hl_inc_wrap: got %h want 0000", hl_out); else n_pass++;
    n_total++; if (rd_data !== 8'h00) $display("FAIL hl_inc_fwd: got %h want 00", rd_data); else n_pass++;
    hl_dec = 1'b1; tick(); idle();
    n_total++; if (hl_out !== 16'hFFFF) $display("FAIL hl_dec_wrap: got %h want ffff", hl_out); else n_pass++;
    hl_inc = 1'b1; hl_dec = 1'b1; tick(); idle();
    n_total++; if (hl_out !== 16'hFFFF) $display("FAIL hl_both: got %h want ffff", hl_out); else n_pass++;
  endtask

  task automatic test_collision();
    idle(); pair_wr_en = 1'b1; pair_sel = 2'd2; pair_data = 16'h1234;
    reg_wr_en = 1'b1; reg_wr_addr = 3'd5; reg_src_sel = 2'd0; sbus_data = 8'h99;
    hl_inc = 1'b1; tick(); idle();
    n_total++; if (hl_out !== 16'h1234) $display("FAIL collide_hl: got %h want 1234", hl_out); else n_pass++;
    reg_wr_en = 1'b1; reg_wr_addr = 3'd5; reg_src_sel = 2'd3; debug_data = 8'h80; hl_dec = 1'b1; tick(); idle();
    n_total++; if (hl_out !== 16'h1280) $display("FAIL wr_l_blocks_dec: got %h want 1280", hl_out); else n_pass++;
  endtask

  task automatic test_flags();
    idle(); flag_wr_en = 1'b1; flag_in = 4'b1010; tick(); idle();
    n_total++; if (f_out !== 8'hA0) $display("FAIL flag_wr: got %h want a0", f_out); else n_pass++;
    pair_wr_en = 1'b1; pair_sel = 2'd3; pair_data = 16'h12FF; flag_wr_en = 1'b1; flag_in = 4'h0; tick(); idle();
    n_total++; if (a_out !== 8'h12) $display("FAIL af_a: got %h want 12", a_out); else n_pass++;
    n_total++; if (f_out !== 8'hF0) $display("FAIL af_f: got %h want f0", f_out); else n_pass++;
  endtask

  task automatic test_mem_slot_and_rst();
    idle(); reg_wr_en = 1'b1; reg_wr_addr = 3'd6; reg_src_sel = 2'd0; sbus_data = 8'h77;
    reg_rd_en = 1'b1; reg_rd_addr = 3'd6; tick(); idle();
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 8'h00)
      $display("FAIL read_mem: got valid=%b data=%h want 1/00", rd_valid, rd_data); else n_pass++;
    n_total++; if (a_out !== 8'h12 || f_out !== 8'hF0 || hl_out !== 16'h1280)
      $display("FAIL wr_mem_nochange: got a=%h f=%h hl=%h want 12/f0/1280", a_out, f_out, hl_out); else n_pass++;
    reg_rd_en = 1'b1; reg_rd_addr = 3'd0; tick(); idle();
    n_total++; if (rd_data !== 8'h5A) $display("FAIL b_kept: got %h want 5a", rd_data); else n_pass++;
    rst = 1'b1; reg_rd_en = 1'b1; reg_rd_addr = 3'd7; reg_wr_en = 1'b1; reg_wr_addr = 3'd7;
    sbus_data = 8'hEE; tick(); idle();
    n_total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00)
      $display("FAIL rst_mid_read: got valid=%b data=%h want 0/00", rd_valid, rd_data); else n_pass++;
    n_total++; if (a_out !== 8'h01) $display("FAIL rst_discard_wr: got %h want 01", a_out); else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 39) == 0);
      reg_rd_en   = $urandom_range(0, 1) == 1;
      reg_rd_addr = 3'($urandom_range(0, 7));
      reg_wr_en   = $urandom_range(0, 1) == 1;
      reg_wr_addr = 3'($urandom_range(0, 7));
      reg_src_sel = 2'($urandom_range(0, 3));
      sbus_data   = 8'($urandom); alu_data = 8'($urandom);
      mem_data    = 8'($urandom); debug_data = 8'($urandom);
      pair_wr_en  = ($urandom_range(0, 3) == 0);
      pair_sel    = 2'($urandom_range(0, 3));
      pair_data   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      flag_wr_en  = $urandom_range(0, 1) == 1;
      flag_in     = 4'($urandom);
      hl_inc      = $urandom_range(0, 1) == 1;
      hl_dec      = $urandom_range(0, 1) == 1;
      tick();
      n_total++; if (a_out !== m_reg[7]) $display("FAIL rnd_a[%0d]: got %h want %h", n, a_out, m_reg[7]); else n_pass++;
      n_total++; if (f_out !== m_f) $display("FAIL rnd_f[%0d]: got %h want %h", n, f_out, m_f); else n_pass++;
      n_total++; if (hl_out !== {m_reg[4], m_reg[5]})
        $display("FAIL rnd_hl[%0d]: got %h want %h", n, hl_out, {m_reg[4], m_reg[5]}); else n_pass++;
      n_total++; if (rd_valid !== m_valid) $display("FAIL rnd_valid[%0d]: got %b want %b", n, rd_valid, m_valid); else n_pass++;
      n_total++; if (rd_data !== m_rd) $display("FAIL rnd_rd[%0d]: got %h want %h", n, rd_data, m_rd); else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_write_forward();
    test_hl_wrap();
    test_collision();
    test_flags();
    test_mem_slot_and_rst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

CPU general-purpose register file: the responder to the instruction decoder's register control bus. Stores B, C, D, E, H, L, A and the F flag register; each cycle it accepts one 8-bit read, one 8-bit write selected from four data sources, an optional 16-bit pair write, a flag update and an HL increment/decrement. It exposes A, F and HL continuously for the ALU and the memory address path.

## Interface
Parameters:
- POST_BOOT, 1: reset values. 1 gives DMG post-boot state (A=01 F=B0 B=00 C=13 D=00 E=D8 H=01 L=4D); 0 resets all registers to 00.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- reg_rd_en  in  1  capture a read this cycle
- reg_rd_addr  in  3  read register (B=000 C=001 D=010 E=011 H=100 L=101 (HL)=110 A=111)
- reg_wr_en  in  1  8-bit write this cycle
- reg_wr_addr  in  3  write register, same encoding
- reg_src_sel  in  2  write source: SBUS=00, ALU=01, MEM=10, DEBUG=11
- sbus_data, alu_data, mem_data, debug_data  in  8 each  write source data
- pair_wr_en  in  1  16-bit pair write
- pair_sel  in  2  BC=00 DE=01 HL=10 AF=11
- pair_data  in  16  pair write data, high byte to first register
- flag_wr_en  in  1  update F
- flag_in  in  4  Z N H C, written to F[7:4]
- hl_inc, hl_dec  in  1 each  post-increment/decrement HL
- rd_data  out  8  registered read data
- rd_valid  out  1  pulses one cycle after an accepted read
- a_out  out  8  current A
- f_out  out  8  current F
- hl_out  out  16  current {H,L}

## Operation
- Write data mux: reg_src_sel selects sbus/alu/mem/debug_data.
- 8-bit write to addr 110 is ignored (memory writes belong to the bus unit); no register changes.
- Read of addr 110 returns 8'h00 with rd_valid still asserted.
- F[3:0] is always 0: flag writes, AF pair writes and reset all force it; pair AF writes A=pair_data[15:8], F=pair_data[7:4],0000.
- F is not reachable via the 3-bit address.
- Priority when targets collide in one cycle: rst > pair write > 8-bit write > flag write (F only) > hl_inc/hl_dec.
- Any 8-bit write to H or L, or pair write to HL, suppresses hl_inc/hl_dec that cycle.
- hl_inc and hl_dec both high: HL unchanged.
- HL arithmetic is 16-bit modulo: FFFF+1=0000, 0000-1=FFFF, carry propagates L to H.
- Read forwarding (write-first): if the read address matches a register written in the same cycle (8-bit, pair or HL inc/dec), rd_data captures the new value.
- rd_data holds its last value while reg_rd_en is low.

## Timing
- Writes, flag updates and HL inc/dec commit on the rising edge of the cycle they are asserted; visible on a_out/f_out/hl_out in the next cycle (outputs are flop-direct, no combinational path from inputs).
- Read latency 1: rd_data and rd_valid valid the cycle after reg_rd_en; throughput one read per cycle.
- Reset values: rd_data=00, rd_valid=0, registers per POST_BOOT; a_out/f_out/hl_out reflect them the cycle after rst is sampled.
- rst asserted mid-operation discards all same-cycle writes and reads; rd_valid is 0 the following cycle.
- No handshake back-pressure: every request is accepted.

## Structure
- Shared package gb_pkg: register encodings REG_A..REG_L, MEM_HL; source select codes SBUS, ALU, MEM, DEBUG; pair codes; post-boot reset constants.
- The decoder imports the same package; no local copies of encodings.
- One natural sub-module: reg_src_mux (4:1 8-bit write-source mux). Storage, priority and forwarding stay in reg_file.

## Test plan
- Reset, POST_BOOT=1: after rst, a_out=01, f_out=B0, hl_out=014D; read C -> rd_data=13, rd_valid=1 one cycle later.
- Write B from ALU (alu_data=5A, src=01) while reading B in the same cycle -> rd_data=5A next cycle; read again -> 5A.
- HL wrap: pair write HL=FFFF, then hl_inc -> hl_out=0000; hl_dec -> FFFF; inc+dec together -> unchanged.
- Collision: pair write HL=1234 plus 8-bit write L=99 plus hl_inc in one cycle -> hl_out=1234.
- Flags: flag_in=1010 -> f_out=A0; AF pair write 12FF -> a_out=12, f_out=F0.
- Write to addr 110 with sbus_data=77 -> no register changes; read 110 -> rd_data=00; rst mid-read -> rd_valid=0 next cycle.
